// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RISC-V pipeline: register-address
// width, the hardwired zero register, and the hazard sequencer state encoding.
package riscv_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_HOLD = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector. It flags an ID-stage instruction
// that reads the destination of a load still sitting in EX. Writes to x0 are
// discarded by the register file, so they never create a dependency.
module load_use_detect
    import riscv_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    output logic                  o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_hazard  = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It resolves the hazards
// forwarding cannot: load-use bubbles, multi-cycle mul/div occupancy of EX,
// data-memory wait states and taken-branch flushes.
// Priority: memory freeze > mul/div wait > branch flush > load-use stall.
// Optional stall/flush statistics counters: define HAZARD_STALL_CNT_EN.
// The FSM state is exposed on dbg_st for observation.
module pipeline_hazard_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_md_valid,
    input  logic                  md_done,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  ex_branch_taken,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_bubble,
    output logic                  mem_wb_bubble,
    output logic                  md_start,
    output logic                  md_timeout,
`ifdef HAZARD_STALL_CNT_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
`endif
    output logic [1:0]            dbg_st
);

    // Last MD_WAIT count value before the mul/div is abandoned.
    localparam logic [7:0] LP_CYC_LAST = 8'(MD_TIMEOUT - 1);

    hazard_state_t r_st;
    logic [7:0]    r_cyc;
    logic          r_md_timeout;

    hazard_state_t w_nxt_st;
    logic [7:0]    w_nxt_cyc;
    logic          w_set_timeout;
    logic          w_freeze;
    logic          w_load_use;

    assign w_freeze   = dmem_req && !dmem_ready;
    assign md_timeout = r_md_timeout;
    assign dbg_st     = r_st;

    load_use_detect u_load_use_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_rd       (ex_rd),
        .i_ex_mem_read (ex_mem_read),
        .o_hazard      (w_load_use)
    );

    // Priority mux: pipeline-register controls and next FSM state.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        md_start      = 1'b0;
        w_nxt_st      = r_st;
        w_nxt_cyc     = r_cyc;
        w_set_timeout = 1'b0;

        if (rst) begin
            // Flush every stage while in reset so nothing stale survives.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (w_freeze) begin
            // Memory wait: hold everything up to EX/MEM, drain a NOP into WB.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            // A done pulse arriving while frozen is remembered in MD_HOLD.
            if (r_st == MD_WAIT && md_done) begin
                w_nxt_st = MD_HOLD;
            end
        end else begin
            case (r_st)
                MD_WAIT, MD_HOLD: begin
                    w_nxt_cyc = r_cyc + 8'd1;
                    if (r_st == MD_HOLD || md_done) begin
                        // Result is captured into EX/MEM; pipeline resumes.
                        w_nxt_st = RUN;
                    end else if (r_cyc == LP_CYC_LAST) begin
                        // Abandon the mul/div: squash it and raise the flag.
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        id_ex_flush   = 1'b1;
                        w_set_timeout = 1'b1;
                        w_nxt_st      = RUN;
                    end else begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end
                end
                default: begin
                    if (ex_md_valid) begin
                        md_start      = 1'b1;
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        w_nxt_st      = MD_WAIT;
                        w_nxt_cyc     = 8'd0;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        // One bubble suffices: the load leaves EX next cycle.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st         <= RUN;
            r_cyc        <= 8'd0;
            r_md_timeout <= 1'b0;
        end else begin
            r_st  <= w_nxt_st;
            r_cyc <= w_nxt_cyc;
            if (w_set_timeout) begin
                r_md_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating statistics: PC-stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && stall_cycles != {CNT_W{1'b1}}) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (if_id_flush && flush_count != {CNT_W{1'b1}}) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the ALU forwarding logic and covers the hazards forwarding cannot resolve:
- load-use bubbles
- multi-cycle mul/div occupancy of EX
- data-memory wait states
- taken-branch flushes

It drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_WAIT before abort (range 2..255)
CNT_W, 32, width of stall counter (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
id_rs1  in  5  ID-stage source reg 1
id_rs2  in  5  ID-stage source reg 2
id_uses_rs1  in  1  ID instr reads rs1
id_uses_rs2  in  1  ID instr reads rs2
ex_rd  in  5  EX-stage destination
ex_mem_read  in  1  EX instr is a load
ex_md_valid  in  1  EX instr is mul/div
md_done  in  1  mul/div result valid (single-cycle pulse)
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes this cycle
ex_branch_taken  in  1  EX redirect (branch/jump taken)
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_flush  out  1  ID/EX loads NOP
ex_mem_bubble  out  1  EX/MEM loads NOP
mem_wb_bubble  out  1  MEM/WB loads NOP
md_start  out  1  one-cycle start pulse to mul/div
md_timeout  out  1  sticky abort flag

Behaviour:
- Registered state: st in {RUN, MD_WAIT, MD_HOLD}; cyc counter 8b; md_timeout.
- Reset (rst=1 at posedge): st=RUN, cyc=0, md_timeout=0.
- While rst=1, outputs are forced: all *_en=1, if_id_flush=id_ex_flush=ex_mem_bubble=mem_wb_bubble=1, md_start=0.
- Outputs are combinational from st and inputs. Default: all en=1, all flush/bubble=0, md_start=0.
- Evaluation priority: mem freeze > MD_WAIT/MD_HOLD > branch > load-use.
- Mem freeze (dmem_req && !dmem_ready, any state):
  - pc/if_id/id_ex/ex_mem en=0; mem_wb_bubble=1; md_start=0; branch ignored.
  - st does not advance, except MD_WAIT with md_done=1 goes to MD_HOLD.
- RUN, ex_md_valid=1, no freeze:
  - md_start=1; pc/if_id/id_ex en=0; ex_mem_bubble=1.
  - Next st=MD_WAIT, cyc=0.
- MD_WAIT: pc/if_id/id_ex en=0; ex_mem_bubble=1; cyc++ each unfrozen cycle.
  - md_done=1, no freeze: bubble=0 (result captured into EX/MEM), all en=1, next RUN.
  - cyc==MD_TIMEOUT-1 and no done: md_timeout<=1, bubble=1, id_ex_flush=1, next RUN.
- MD_HOLD: same outputs as MD_WAIT until freeze clears. On the first unfrozen cycle, behaves as MD_WAIT with md_done=1. md_done pulses are never lost.
- Branch (RUN, no md, no freeze): if_id_flush=1, id_ex_flush=1, pc_en=1. Suppresses any load-use stall in the same cycle.
- Load-use (RUN, no branch/md/freeze):
  - Condition: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble, because the load leaves EX next cycle.
- ex_rd==0 never stalls.
- md_timeout is cleared only by rst.
- rst during MD_WAIT returns to RUN; the mul/div must be reset by the same rst.

Optional Feature:
Macro HAZARD_STALL_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0] and flush_count[CNT_W-1:0], both reset to 0.
  - stall_cycles increments on every cycle with pc_en=0 (rst=0).
  - flush_count increments on every cycle with if_id_flush=1 (rst=0).
  - Both saturate at all-ones.
- Undefined: ports and logic absent; otherwise identical behaviour.

Decomposition:
- Package riscv_ctrl_pkg:
  - hazard state enum (RUN=2'd0, MD_WAIT=2'd1, MD_HOLD=2'd2)
  - REG_ZERO=5'd0
  - REG_ADDR_W=5
- One combinational sub-module, load_use_detect (rs1/rs2/ex_rd compare), reusable by the forwarding path.
- FSM, counter and priority mux live in the top module.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5); ID add reads id_rs2=5, id_uses_rs2=1 -> single cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1.
- Same as above but ex_rd=0, or id_uses_rs2=0 -> no stall.
- ex_md_valid=1; md_done after 4 cycles -> md_start pulses 1 cycle; 4 stall cycles with ex_mem_bubble=1; done cycle ex_mem_bubble=0; st=RUN.
- MD_WAIT with dmem_req=1, dmem_ready=0 for 3 cycles; md_done pulses in the 2nd -> st=MD_HOLD, mem_wb_bubble=1; release cycle has bubble=0; then RUN.
- MD_TIMEOUT=8, md_done never asserted -> md_timeout=1 after 8 cycles, id_ex_flush=1, st=RUN; flag stays 1 until rst.
- ex_branch_taken=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_en=1, no stall; with HAZARD_STALL_CNT_EN, flush_count +1 and stall_cycles unchanged.
